symbol_strobe_packetizer: RTL and testbench

SYMBOL_STROBE_PACKETIZER -- requirements
Module: symbol_strobe_packetizer

---
 rtl/symbol_strobe_packetizer.sv | 137 +++++++++++++
 tb/tb_symbol_strobe_packetizer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/symbol_strobe_packetizer.sv
// Purpose: keeps one input sample per symbol (strobe mode) or one in n (fixed mode) and frames the kept samples into packets.
// Latency: a selected beat appears on the output one cycle after it is accepted, data unmodified.
// Backpressure: one output register; i_tready = ~o_tvalid | o_tready, output held while stalled.
module symbol_strobe_packetizer #(
    parameter int WIDTH = 32,
    parameter int N_W   = 16,
    parameter int LEN_W = 12
) (
    input  logic             ce_clk,
    input  logic             ce_rst,
    input  logic             clear,
    input  logic             mode,
    input  logic [N_W-1:0]   n,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic             sym_stb,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [15:0]      drop_cnt
);

    logic             pending;
    logic             last_pending;
    logic             mode_q;
    logic [N_W-1:0]   phase;
    logic [LEN_W-1:0] pkt_cnt;

    logic             accept;
    logic             mode_chg;
    logic             stb;
    logic             pending_eff;
    logic [N_W-1:0]   phase_eff;
    logic [N_W-1:0]   n_last;
    logic [LEN_W-1:0] len_last;
    logic             sel;
    logic             tlast_sel;

    // The output register frees up either when empty or when it is being drained this cycle.
    assign i_tready = ~o_tvalid | o_tready;
    assign accept   = i_tvalid & i_tready;

    // Selection and framing decisions for the beat presented this cycle.
    always_comb begin
        mode_chg    = mode ^ mode_q;
        stb         = sym_stb & ~mode;
        // A mode switch behaves as if phase and pending were already zero this cycle.
        pending_eff = pending & ~mode_chg & ~mode;
        phase_eff   = mode_chg ? '0 : phase;
        // max(n,1)-1 and max(pkt_len,1)-1, so a zero setting means "every beat".
        n_last      = (n == '0) ? '0 : n - N_W'(1);
        len_last    = (pkt_len == '0) ? '0 : pkt_len - LEN_W'(1);
        sel         = accept & (mode ? (phase_eff >= n_last) : (stb | pending_eff));
        // >= so that shrinking pkt_len mid-packet closes the packet at once.
        tlast_sel   = i_tlast | last_pending | (pkt_cnt >= len_last);
    end

    // Symbol tracking: strobe pending flag, lost-strobe counter and fixed-mode phase.
    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            pending  <= 1'b0;
            drop_cnt <= '0;
            phase    <= '0;
            mode_q   <= 1'b0;
        end else if (clear) begin
            pending  <= 1'b0;
            drop_cnt <= '0;
            phase    <= '0;
            mode_q   <= mode;
        end else begin
            mode_q <= mode;
            if (mode) begin
                pending <= 1'b0;
            end else if (sel) begin
                // An older strobe was consumed; a coincident new one waits for the next beat.
                pending <= pending_eff & stb;
            end else begin
                pending <= pending_eff | stb;
            end
            // A second strobe arriving before any beat could be taken is lost.
            if (stb && pending_eff && !accept && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (!mode) begin
                phase <= '0;
            end else if (accept) begin
                phase <= sel ? '0 : phase_eff + N_W'(1);
            end else begin
                phase <= phase_eff;
            end
        end
    end

    // Packet framing: output sample counter and carried-over input tlast.
    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            last_pending <= 1'b0;
            pkt_cnt      <= '0;
        end else if (clear) begin
            last_pending <= 1'b0;
            pkt_cnt      <= '0;
        end else begin
            if (sel) begin
                last_pending <= 1'b0;
                pkt_cnt      <= tlast_sel ? '0 : pkt_cnt + LEN_W'(1);
            end else if (accept && i_tlast) begin
                last_pending <= 1'b1;
            end
        end
    end

    // Output register: loads selected beats, empties when drained with nothing new selected.
    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            o_tvalid <= 1'b0;
            o_tlast  <= 1'b0;
            o_tdata  <= '0;
        end else if (clear) begin
            o_tvalid <= 1'b0;
            o_tlast  <= 1'b0;
            o_tdata  <= '0;
        end else if (accept) begin
            o_tvalid <= sel;
            if (sel) begin
                o_tdata <= i_tdata;
                o_tlast <= tlast_sel;
            end
        end else if (o_tready) begin
            o_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_symbol_strobe_packetizer.sv
// Purpose: randomized and directed checking of symbol_strobe_packetizer against an in-bench behavioural model.
// Latency: model predicts the output register contents for every cycle.
// Backpressure: o_tready is randomized; the model tracks occupancy of the single output slot.
module tb_symbol_strobe_packetizer;

    logic        ce_clk = 1'b0;
    logic        ce_rst = 1'b1;
    logic        clear = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] n = 16'd1;
    logic [11:0] pkt_len = 12'd1;
    logic        sym_stb = 1'b0;
    logic [31:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b1;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    symbol_strobe_packetizer dut (
        .ce_clk(ce_clk), .ce_rst(ce_rst), .clear(clear), .mode(mode), .n(n),
        .pkt_len(pkt_len), .sym_stb(sym_stb), .i_tdata(i_tdata), .i_tlast(i_tlast),
        .i_tvalid(i_tvalid), .i_tready(i_tready), .o_tdata(o_tdata), .o_tlast(o_tlast),
        .o_tvalid(o_tvalid), .o_tready(o_tready), .drop_cnt(drop_cnt)
    );

    always #5 ce_clk = ~ce_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Slot = what the single output register must hold; owed = strobes waiting for a beat (0 or 1);
    // since = beats taken since the last kept one; in_pkt = samples already sent in the current packet.
    logic        m_vld = 1'b0;
    logic        m_last = 1'b0;
    logic [31:0] m_dat = '0;
    int          m_owed = 0;
    int          m_since = 0;
    int          m_in_pkt = 0;
    bit          m_lastp = 1'b0;
    int          m_drop = 0;
    bit          m_acc, m_pick, m_lst;
    int          m_ne, m_le, m_wait;

    always @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst || clear) begin
            m_vld = 0; m_last = 0; m_dat = '0; m_owed = 0; m_since = 0;
            m_in_pkt = 0; m_lastp = 0; m_drop = 0;
        end else begin
            m_acc = i_tvalid && (!m_vld || o_tready);
            m_ne  = (n == 0) ? 1 : int'(n);
            m_le  = (pkt_len == 0) ? 1 : int'(pkt_len);
            m_pick = 0;
            if (mode) begin
                if (m_acc) begin
                    m_pick  = (m_since + 1 >= m_ne);
                    m_since = m_pick ? 0 : m_since + 1;
                end
            end else begin
                m_wait = m_owed + (sym_stb ? 1 : 0);
                if (m_acc && m_wait > 0) begin
                    m_pick = 1;
                    m_wait = m_wait - 1;
                end
                if (m_wait > 1) begin
                    if (m_drop < 65535) m_drop = m_drop + (m_wait - 1);
                    m_wait = 1;
                end
                m_owed = m_wait;
            end
            if (m_pick) begin
                m_lst    = i_tlast || m_lastp || (m_in_pkt + 1 >= m_le);
                m_in_pkt = m_lst ? 0 : m_in_pkt + 1;
                m_lastp  = 0;
                m_dat    = i_tdata;
                m_last   = m_lst;
            end else if (m_acc && i_tlast) begin
                m_lastp = 1;
            end
            if (m_acc) m_vld = m_pick;
            else if (o_tready) m_vld = 0;
        end
    end

    // Every-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge ce_clk) begin
        if (!ce_rst) begin
            check("o_tvalid", o_tvalid, m_vld);
            check("i_tready", i_tready, !m_vld || o_tready);
            check("drop_cnt", drop_cnt, m_drop);
            if (m_vld) begin
                check("o_tdata", o_tdata, m_dat);
                check("o_tlast", o_tlast, m_last);
            end
        end
    end

    // Record every output handshake for the directed literal checks.
    logic [32:0] cap[$];
    always @(posedge ce_clk) begin
        if (!ce_rst && o_tvalid && o_tready) cap.push_back({o_tlast, o_tdata});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge ce_clk);
        #1;
    endtask

    task automatic setup(input logic md, input logic [15:0] nn, input logic [11:0] ln);
        mode = md; n = nn; pkt_len = ln;
        i_tvalid = 0; sym_stb = 0; i_tlast = 0; o_tready = 1;
        clear = 1;
        tick;
        clear = 0;
        cap.delete();
    endtask

    task automatic drive_beat(input logic [31:0] d);
        bit acc;
        acc = 0;
        i_tvalid = 1; i_tdata = d; i_tlast = 0;
        for (int b = 0; b < 100 && !acc; b++) begin
            @(negedge ce_clk);
            acc = i_tready;
            tick;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL beat_accept_timeout: beat %0d not accepted within 100 cycles", d);
        end
    endtask

    task automatic exp_out(input string name, input int idx, input logic [31:0] d, input logic l);
        if (idx < cap.size()) begin
            check($sformatf("%s[%0d]_dat", name, idx), cap[idx][31:0], d);
            check($sformatf("%s[%0d]_last", name, idx), cap[idx][32], l);
        end else begin
            checks++; errors++;
            $display("FAIL %s[%0d]: got no output, expected data %0d", name, idx, d);
        end
    endtask

    int exp_d[6];
    bit exp_l[6];

    initial begin
        // Reset state
        #3;
        check("rst_o_tvalid", o_tvalid, 0);
        check("rst_o_tlast", o_tlast, 0);
        check("rst_o_tdata", o_tdata, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_i_tready", i_tready, 1);
        #19 ce_rst = 0;
        tick;

        // Fixed mode n=4 pkt_len=3, continuous ramp
        setup(1, 16'd4, 12'd3);
        for (int k = 0; k < 24; k++) begin i_tvalid = 1; i_tdata = k; tick; end
        i_tvalid = 0; tick; tick;
        exp_d = '{3, 7, 11, 15, 19, 23};
        exp_l = '{0, 0, 1, 0, 0, 1};
        check("fixed4_count", cap.size(), 6);
        for (int i = 0; i < 6; i++) exp_out("fixed4", i, exp_d[i], exp_l[i]);

        // Strobe mode, strobes on cycles 5 and 21
        setup(0, 16'd1, 12'd100);
        for (int k = 0; k < 31; k++) begin
            i_tvalid = 1; i_tdata = k; sym_stb = (k == 5 || k == 21); tick;
        end
        i_tvalid = 0; sym_stb = 0; tick; tick;
        check("strobe_count", cap.size(), 2);
        exp_out("strobe", 0, 5, 0);
        exp_out("strobe", 1, 21, 0);

        // Strobes with no input: two lost, one served by next beat
        setup(0, 16'd1, 12'd100);
        for (int k = 0; k < 10; k++) begin
            i_tvalid = 0; sym_stb = (k == 1 || k == 4 || k == 7); tick;
        end
        sym_stb = 0;
        check("drop_two", drop_cnt, 2);
        for (int k = 0; k < 4; k++) begin i_tvalid = 1; i_tdata = 99 + k; tick; end
        i_tvalid = 0; tick; tick;
        check("drop_out_count", cap.size(), 1);
        exp_out("drop_out", 0, 99, 0);

        // Fixed n=2 with a 5-cycle output stall
        setup(1, 16'd2, 12'd100);
        fork
            begin
                for (int k = 0; k < 10; k++) drive_beat(k);
                i_tvalid = 0;
            end
            begin
                int b;
                b = 0;
                while (!o_tvalid && b < 50) begin tick; b++; end
                if (!o_tvalid) begin
                    checks++; errors++;
                    $display("FAIL stall_wait: got no o_tvalid within 50 cycles, expected one");
                end
                o_tready = 0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge ce_clk);
                    check("stall_i_tready", i_tready, 0);
                    check("stall_o_tdata", o_tdata, 1);
                    tick;
                end
                o_tready = 1;
            end
        join
        tick; tick; tick;
        check("stall_count", cap.size(), 5);
        for (int i = 0; i < 5; i++) exp_out("stall", i, 2 * i + 1, 0);

        // Input tlast on unselected beat 5 closes the packet at the next kept sample
        setup(1, 16'd4, 12'd8);
        for (int k = 0; k < 12; k++) begin
            i_tvalid = 1; i_tdata = k; i_tlast = (k == 5); tick;
        end
        i_tvalid = 0; i_tlast = 0; tick; tick;
        check("early_count", cap.size(), 3);
        exp_out("early", 0, 3, 0);
        exp_out("early", 1, 7, 1);
        exp_out("early", 2, 11, 0);

        // Asynchronous reset mid-packet with a held output and nonzero drop count
        setup(0, 16'd1, 12'd4);
        for (int k = 0; k < 6; k++) begin
            i_tvalid = 0; sym_stb = (k == 1 || k == 3 || k == 5); tick;
        end
        check("pre_rst_drop", drop_cnt, 2);
        for (int k = 0; k < 2; k++) begin
            i_tvalid = 1; i_tdata = 50 + k; sym_stb = 1; tick;
        end
        i_tvalid = 0; sym_stb = 0;
        check("pre_rst_o_tvalid", o_tvalid, 1);
        #1 ce_rst = 1;
        #1;
        check("rst_async_o_tvalid", o_tvalid, 0);
        check("rst_async_drop", drop_cnt, 0);
        tick;
        ce_rst = 0;
        tick;
        cap.delete();
        for (int k = 0; k < 6; k++) begin
            i_tvalid = 1; i_tdata = 10 + k; sym_stb = 1; tick;
        end
        i_tvalid = 0; sym_stb = 0; tick; tick;
        check("post_rst_count", cap.size(), 6);
        for (int i = 0; i < 6; i++) exp_out("post_rst", i, 10 + i, i == 3);

        // Randomized traffic
        setup($urandom_range(0, 1), 16'($urandom_range(0, 5)), 12'($urandom_range(0, 6)));
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                setup($urandom_range(0, 1), 16'($urandom_range(0, 5)), 12'($urandom_range(0, 6)));
            end
            if ($urandom_range(0, 99) == 0) n = 16'($urandom_range(0, 5));
            if ($urandom_range(0, 99) == 0) pkt_len = 12'($urandom_range(0, 6));
            i_tvalid = ($urandom_range(0, 9) < 6);
            i_tdata  = $urandom;
            i_tlast  = ($urandom_range(0, 9) == 0);
            sym_stb  = ($urandom_range(0, 9) < 3);
            o_tready = ($urandom_range(0, 9) < 7);
            tick;
        end
        i_tvalid = 0; sym_stb = 0; o_tready = 1;
        tick; tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
